freq_controller: RTL and testbench

Programmable clock-rate controller for the lab CPU: the parametrised successor of the fixed-tap frequency reducer. It divides the board clock by a runtime-selectable power of two and supports run, halt and single-step modes. It produces both a divided clock and a one-cycle tick that downstream logic uses as a clock enable. It sits between the board clock/buttons and the CPU core.

---
 rtl/freq_ctrl_pkg.sv | 14 +
 rtl/freq_controller_sync_edge.sv | 30 +++
 rtl/freq_controller.sv | 142 ++++++++++++++
 tb/tb_freq_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_ctrl_pkg.sv
// Purpose: shared mode encoding and tick-counter width for the clock-rate controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package freq_ctrl_pkg;

  localparam int TICKS_W = 16;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

endpackage

// File: rtl/freq_controller_sync_edge.sv
// Purpose: two-flop synchroniser plus rising-edge detector for an asynchronous button.
// Latency: o_rise is high for one cycle, two edges after the raw level is first sampled high.
// Backpressure: none; a rise that the consumer does not act on is simply lost.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Metastability filter (r_s1, r_s2) followed by the edge-history flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_controller.sv
// Purpose: divides the board clock by a runtime-selected power of two, with run/halt/single-step.
// Latency: saida/tick follow the counter flop directly; halt acts on the first sampling edge, step 3 edges after press.
// Backpressure: none; step presses outside HALT are dropped, out-of-range tap loads are ignored.
module freq_controller
  import freq_ctrl_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int RESET_SEL = 18,
  localparam int SEL_W     = $clog2(WIDTH)
) (
  input  logic               entrada,
  input  logic               reset,
  input  logic               halt,
  input  logic               step,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_load,
  output logic               saida,
  output logic               tick,
  output logic [1:0]         state,
  output logic [TICKS_W-1:0] ticks
);

  localparam logic [WIDTH-1:0] ONES    = '1;
  localparam logic [SEL_W-1:0] TOP_SEL = SEL_W'(WIDTH - 1);

  logic [WIDTH-1:0]   r_count;
  logic [WIDTH-1:0]   w_count_nxt;
  logic [WIDTH-1:0]   w_term;
  logic [SEL_W-1:0]   r_sel_q;
  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_saida_d;
  logic [TICKS_W-1:0] r_ticks;
  logic               w_rise;
  logic               w_load;
  logic               w_saida;
  logic               w_tick;

  sync_edge u_step_sync (
    .i_clk  (entrada),
    .i_rst  (reset),
    .i_d    (step),
    .o_rise (w_rise)
  );

  // A tap index is only accepted if it names an existing counter bit.
  assign w_load = sel_load && ({1'b0, sel} < (SEL_W + 1)'(WIDTH));

  // Last count of a single step, 2^(sel_q+1)-1, built by shifting ones down so it never overflows.
  assign w_term = ONES >> (TOP_SEL - r_sel_q);

  // Divided clock comes straight off a counter flop bit.
  assign w_saida = r_count[r_sel_q];
  assign w_tick  = w_saida & ~r_saida_d;

  assign saida = w_saida;
  assign tick  = w_tick;
  assign state = r_state;
  assign ticks = r_ticks;

  // Mode transitions and the counter's next value.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      ST_RUN: begin
        if (halt) begin
          w_state_nxt = ST_HALT;
          w_count_nxt = '0;
        end else if (w_load) begin
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + WIDTH'(1);
        end
      end
      ST_HALT: begin
        w_count_nxt = '0;
        if (!halt) begin
          w_state_nxt = ST_RUN;
        end else if (w_rise) begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        // A tap reload restarts the step; otherwise run one full period and leave.
        if (w_load) begin
          w_count_nxt = '0;
        end else if (r_count == w_term) begin
          w_count_nxt = '0;
          w_state_nxt = halt ? ST_HALT : ST_RUN;
        end else begin
          w_count_nxt = r_count + WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_count_nxt = '0;
      end
    endcase
  end

  // Mode register.
  always_ff @(posedge entrada or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Divider counter.
  always_ff @(posedge entrada or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  // Tap register, updated only by an in-range load.
  always_ff @(posedge entrada or posedge reset) begin
    if (reset) begin
      r_sel_q <= SEL_W'(RESET_SEL);
    end else if (w_load) begin
      r_sel_q <= sel;
    end
  end

  // Previous divided-clock level and the running count of tick pulses.
  always_ff @(posedge entrada or posedge reset) begin
    if (reset) begin
      r_saida_d <= 1'b0;
      r_ticks   <= '0;
    end else begin
      r_saida_d <= w_saida;
      if (w_tick) begin
        r_ticks <= r_ticks + TICKS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_freq_controller.sv
// Bench for freq_controller (WIDTH=8, RESET_SEL=2) plus a WIDTH=6 instance for out-of-range tap loads.
module tb_freq_controller;
  import freq_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int RS = 2;

  logic        entrada = 1'b0;
  logic        reset;
  logic        halt;
  logic        step;
  logic [2:0]  sel;
  logic        sel_load;
  logic        saida;
  logic        tick;
  logic [1:0]  state;
  logic [15:0] ticks;

  logic        halt6;
  logic        step6;
  logic [2:0]  sel6;
  logic        sel_load6;
  logic        saida6;
  logic        tick6;
  logic [1:0]  state6;
  logic [15:0] ticks6;

  freq_controller #(.WIDTH(W), .RESET_SEL(RS)) dut (
    .entrada(entrada), .reset(reset), .halt(halt), .step(step), .sel(sel),
    .sel_load(sel_load), .saida(saida), .tick(tick), .state(state), .ticks(ticks)
  );

  freq_controller #(.WIDTH(6), .RESET_SEL(RS)) dut6 (
    .entrada(entrada), .reset(reset), .halt(halt6), .step(step6), .sel(sel6),
    .sel_load(sel_load6), .saida(saida6), .tick(tick6), .state(state6), .ticks(ticks6)
  );

  always #5 entrada = ~entrada;

  int checks = 0;
  int errors = 0;

  // Reference model state, kept in plain integers.
  int m_cnt, m_sel, m_mode, m_ticks, cyc6;
  bit m_sd, h0, h1, h2;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_sel = RS; m_mode = 0; m_ticks = 0;
    m_sd = 0; h0 = 0; h1 = 0; h2 = 0; cyc6 = 0;
  endfunction

  function automatic int m_saida();
    return (m_cnt >> m_sel) & 1;
  endfunction

  function automatic void model_edge();
    int  s;
    int  period;
    bit  rise;
    bit  load;
    s = m_saida();
    if (s == 1 && m_sd == 0) m_ticks = (m_ticks + 1) % 65536;
    m_sd = (s == 1);
    rise = h1 && !h2;
    h2 = h1; h1 = h0; h0 = step;
    load = sel_load && (int'(sel) < W);
    period = 1 << (m_sel + 1);
    case (m_mode)
      0: begin
        if (halt) begin m_mode = 1; m_cnt = 0; end
        else m_cnt = load ? 0 : (m_cnt + 1) % (1 << W);
      end
      1: begin
        m_cnt = 0;
        if (!halt) m_mode = 0;
        else if (rise) m_mode = 2;
      end
      default: begin
        if (load) m_cnt = 0;
        else if (m_cnt == period - 1) begin m_cnt = 0; m_mode = halt ? 1 : 0; end
        else m_cnt = m_cnt + 1;
      end
    endcase
    if (load) m_sel = int'(sel);
    cyc6++;
  endfunction

  function automatic void check_model();
    int es;
    es = m_saida();
    chk("saida", saida, es);
    chk("tick", tick, (es == 1 && m_sd == 0) ? 1 : 0);
    chk("state", state, m_mode);
    chk("ticks", ticks, m_ticks);
    chk("saida_w6", saida6, (cyc6 >> 2) & 1);
  endfunction

  task automatic cyc(input bit chk_model);
    @(posedge entrada);
    if (reset) model_reset();
    else model_edge();
    #1;
    if (chk_model) check_model();
  endtask

  typedef struct {
    bit         halt;
    bit         sel_load;
    logic [2:0] sel;
    bit         e_saida;
    bit         e_tick;
    logic [1:0] e_state;
    int         e_ticks;
  } vec_t;

  vec_t tv[14];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    // Hand-derived sequence from reset release with RESET_SEL=2.
    tv[0]  = '{0, 0, 3'd0, 0, 0, 2'd0, 0};
    tv[1]  = '{0, 0, 3'd0, 0, 0, 2'd0, 0};
    tv[2]  = '{0, 0, 3'd0, 0, 0, 2'd0, 0};
    tv[3]  = '{0, 0, 3'd0, 1, 1, 2'd0, 0};
    tv[4]  = '{0, 0, 3'd0, 1, 0, 2'd0, 1};
    tv[5]  = '{1, 0, 3'd0, 0, 0, 2'd1, 1};
    tv[6]  = '{1, 0, 3'd0, 0, 0, 2'd1, 1};
    tv[7]  = '{0, 0, 3'd0, 0, 0, 2'd0, 1};
    tv[8]  = '{0, 0, 3'd0, 0, 0, 2'd0, 1};
    tv[9]  = '{0, 1, 3'd0, 0, 0, 2'd0, 1};
    tv[10] = '{0, 0, 3'd0, 1, 1, 2'd0, 1};
    tv[11] = '{0, 0, 3'd0, 0, 0, 2'd0, 2};
    tv[12] = '{0, 0, 3'd0, 1, 1, 2'd0, 2};
    tv[13] = '{0, 0, 3'd0, 0, 0, 2'd0, 3};

    reset = 1; halt = 0; step = 0; sel = 0; sel_load = 0;
    halt6 = 0; step6 = 0; sel6 = 0; sel_load6 = 0;
    model_reset();
    #3;
    chk("rst_saida", saida, 0);
    chk("rst_tick", tick, 0);
    chk("rst_state", state, 0);
    chk("rst_ticks", ticks, 0);
    cyc(0);
    cyc(0);
    reset = 0;

    for (int i = 0; i < 14; i++) begin
      halt = tv[i].halt; sel_load = tv[i].sel_load; sel = tv[i].sel;
      cyc(0);
      chk($sformatf("vec%0d_saida", i), saida, tv[i].e_saida);
      chk($sformatf("vec%0d_tick", i), tick, tv[i].e_tick);
      chk($sformatf("vec%0d_state", i), state, tv[i].e_state);
      chk($sformatf("vec%0d_ticks", i), ticks, tv[i].e_ticks);
    end
    halt = 0; sel_load = 0;

    // Restore tap 2, move into the high half, then halt.
    sel = 3'd2; sel_load = 1; cyc(1); sel_load = 0;
    repeat (5) cyc(1);
    chk("pre_halt_saida", saida, 1);
    halt = 1; cyc(1);
    chk("halt_state", state, 1);
    chk("halt_saida", saida, 0);
    repeat (20) begin cyc(1); chk("halt_hold", saida, 0); end

    // Single step from HALT, with a second press during the step.
    step = 1; cyc(1); step = 0; cyc(1);
    chk("step_wait", state, 1);
    cyc(1);
    chk("step_enter", state, 2);
    t0 = int'(ticks);
    for (int i = 1; i <= 7; i++) begin
      cyc(1);
      if (i == 3) step = 1;
      if (i == 4) step = 0;
    end
    chk("step_len", state, 2);
    cyc(1);
    chk("step_end", state, 1);
    chk("step_tick", ticks, t0 + 1);
    repeat (6) cyc(1);
    chk("step_not_queued", state, 1);

    // Release halt during a step: the step completes, then RUN.
    step = 1; cyc(1); step = 0; cyc(1); cyc(1);
    chk("step2_enter", state, 2);
    repeat (2) cyc(1);
    halt = 0;
    repeat (5) cyc(1);
    chk("step2_hold", state, 2);
    cyc(1);
    chk("step2_run", state, 0);

    // Reset in the middle of a step under tap 5.
    halt = 1; cyc(1);
    sel = 3'd5; sel_load = 1; cyc(1); sel_load = 0;
    step = 1; cyc(1); step = 0; cyc(1); cyc(1);
    chk("step5_enter", state, 2);
    repeat (10) cyc(1);
    reset = 1;
    #1;
    chk("arst_saida", saida, 0);
    chk("arst_tick", tick, 0);
    chk("arst_state", state, 0);
    chk("arst_ticks", ticks, 0);
    model_reset();
    cyc(1);
    reset = 0; halt = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (i == 3 || i == 11) chk("post_rst_tick", tick, 1);
      if (i == 7) chk("post_rst_low", saida, 0);
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      step = ($urandom_range(0, 19) == 0);
      sel_load = ($urandom_range(0, 39) == 0);
      sel = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      sel_load6 = ($urandom_range(0, 9) == 0);
      sel6 = 3'($urandom_range(6, 7));
      if ($urandom_range(0, 499) == 0) begin
        reset = 1;
        #1;
        model_reset();
        chk("rnd_arst_state", state, 0);
        chk("rnd_arst_ticks", ticks, 0);
        cyc(1);
        reset = 0;
      end else begin
        cyc(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
